// File: rtl/serial_subtractor_pkg.sv
// Shared ALU package: FSM state encoding and default operand width.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
//   start, A, B     : requester -> subtractor (start sampled only while ready=1)
//   ready, done     : subtractor status (done is a one-cycle pulse)
//   D, Bo           : difference and borrow out, held until the next completion
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bo;

    modport master (output start, A, B, input ready, done, D, Bo);
    modport slave  (input start, A, B, output ready, done, D, Bo);

endinterface : serial_subtractor_if

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of serial_subtractor_if (start/A/B in, ready/done/D/Bo out)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    bus
);

    localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] res;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] res_full;
    logic             last_bit;

    full_subtractor_1bit u_fs (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .bin  (borrow),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Only WIDTH-1 earlier bits are kept; the current bit completes the word.
    assign res_full = {bit_d, res};
    assign last_bit = (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shift registers, borrow FF, bit counter, result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            bus.D  <= '0;
            bus.Bo <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.A;
                        op_b   <= bus.B;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    res    <= res_full[WIDTH-1:1];
                    borrow <= bit_bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        bus.D  <= res_full;
                        bus.Bo <= bit_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags registered from the next state so they track the FSM exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
        end else begin
            bus.ready <= (state_next == IDLE);
            bus.done  <= (state_next == DONE);
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W    = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic clk;
    logic rst_n;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned hold_d;
    int unsigned hold_bo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait (bounded) for a falling edge where ready is high.
    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ready) return;
        end
        check("ready_timeout", 32'(bus.ready), 32'd1);
    endtask

    // Run one subtraction and check every cycle of it against the model.
    // poke=1 pulses start with other operands during SHIFT and during DONE.
    task automatic do_op(input int unsigned a, input int unsigned b, input bit poke);
        int unsigned exp_d;
        int unsigned exp_bo;
        exp_d  = (a - b) & MASK;
        exp_bo = (a < b) ? 1 : 0;
        wait_ready();
        bus.A     = W'(a);
        bus.B     = W'(b);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.A = W'($urandom);
        bus.B = W'($urandom);
        // k = edges elapsed since the accepting edge when sampled
        for (int k = 0; k <= W + 1; k++) begin
            if (poke && (k == 1 || k == W)) begin
                bus.start = 1'b1;
                bus.A     = W'(1);
                bus.B     = W'(2);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (k < W) begin
                check("busy_ready", 32'(bus.ready), 32'd0);
                check("busy_done",  32'(bus.done),  32'd0);
                check("hold_d",     32'(bus.D),     hold_d);
                check("hold_bo",    32'(bus.Bo),    hold_bo);
            end else if (k == W) begin
                check("done_pulse", 32'(bus.done),  32'd1);
                check("done_ready", 32'(bus.ready), 32'd0);
                check("result_d",   32'(bus.D),     exp_d);
                check("result_bo",  32'(bus.Bo),    exp_bo);
            end else begin
                check("done_clear", 32'(bus.done),  32'd0);
                check("ready_back", 32'(bus.ready), 32'd1);
                check("keep_d",     32'(bus.D),     exp_d);
                check("keep_bo",    32'(bus.Bo),    exp_bo);
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        hold_d  = exp_d;
        hold_bo = exp_bo;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        hold_d    = 0;
        hold_bo   = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset and idle hold
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(bus.ready), 32'd1);
            check("rst_done",  32'(bus.done),  32'd0);
            check("rst_d",     32'(bus.D),     32'd0);
            check("rst_bo",    32'(bus.Bo),    32'd0);
        end

        // Directed basics
        do_op(9, 3, 1'b0);
        do_op(3, 9, 1'b0);
        do_op(5, 5, 1'b0);
        do_op(0, 15, 1'b0);

        // Start pulses while busy must be dropped
        do_op(12, 4, 1'b1);

        // Reset two cycles into an operation
        wait_ready();
        bus.A     = W'(7);
        bus.B     = W'(2);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done",  32'(bus.done),  32'd0);
        check("abort_d",     32'(bus.D),     32'd0);
        check("abort_bo",    32'(bus.Bo),    32'd0);
        hold_d  = 0;
        hold_bo = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done),  32'd0);
            check("abort_idle",    32'(bus.ready), 32'd1);
        end
        do_op(7, 2, 1'b0);

        // Result hold across a following operation
        do_op(14, 1, 1'b0);
        do_op(2, 6, 1'b0);

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(a, b, 1'b0);
            end
        end

        // Random operands, idle gaps and busy pokes
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op($urandom & MASK, $urandom & MASK, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
